phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter NUM_PHASES, 4, number of non-overlapping phase outputs; legal range 2..8.
REQ-002 Parameter PHASE_CYCLES, 1, clock cycles each phase stays asserted; legal range 1..16.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 run  input  1  level; 1 requests continuous macro-cycles.
REQ-006 step_mode  input  1  level; 1 selects single-step operation.
REQ-007 step  input  1  one-cycle pulse; requests exactly one macro-cycle in step mode.
REQ-008 phase_out  output  NUM_PHASES  registered one-hot phase enables; bit 0 = first phase.
REQ-009 phase_idx  output  3  index of the asserted phase; 0 when idle.
REQ-010 busy  output  1  1 while a macro-cycle is in progress.
REQ-011 cycle_done  output  1  one-cycle pulse on the last clock of each macro-cycle.
REQ-012 macro_count  output  32  count of completed macro-cycles.

Function
REQ-013 The block SHALL implement two states, IDLE and RUN.
- IDLE: phase_out = 0, busy = 0.
- RUN: exactly one phase_out bit high.
REQ-014 IDLE->RUN SHALL occur on a rising edge where one of the following holds:
- run=1 and step_mode=0;
- step=1 and step_mode=1.
REQ-015 phase_out[0] SHALL assert on the same edge that enters RUN, giving one-cycle latency from the sampled request.
REQ-016 Phase sequencing in RUN:
- Each phase SHALL hold for PHASE_CYCLES clocks.
- It then advances to the next index.
- No clock SHALL have zero or more than one phase_out bit high.
REQ-017 At the last clock of phase NUM_PHASES-1:
- cycle_done SHALL pulse.
- macro_count SHALL increment by 1, wrapping from 0xFFFFFFFF to 0.
REQ-018 At that same boundary:
- If run=1 and step_mode=0, the block SHALL continue to phase 0 with no idle gap.
- Otherwise it SHALL return to IDLE.
REQ-019 Deasserting run mid macro-cycle SHALL NOT truncate the cycle; the remaining phases complete first.
REQ-020 step asserted while busy=1 SHALL be ignored and not queued.
REQ-021 Changes to step_mode while busy=1 SHALL take effect only at the next macro-cycle boundary.
REQ-022 run and step both asserted in IDLE:
- step_mode selects which one is honoured.
- Only one macro-cycle starts.
REQ-023 phase_idx SHALL equal the bit position of the high phase_out bit, zero-extended to 3 bits.
REQ-024 All outputs SHALL come directly from flops, with no combinational decode after them, so phase_out is glitch-free.

Reset
REQ-025 reset=0 SHALL immediately force the following, regardless of clock:
- IDLE state;
- phase_out=0, phase_idx=0, busy=0, cycle_done=0, macro_count=0;
- internal phase and sub-cycle counters = 0.
REQ-026 Reset asserted mid macro-cycle SHALL abort it without incrementing macro_count.
REQ-027 After reset deasserts, the first macro-cycle SHALL start per REQ-014 with phase 0.

Configuration
REQ-028 Macro PHASE_SEQ_STEP_EN defined: single-step mode SHALL be present as specified in REQ-006, REQ-007, REQ-014, REQ-020 and REQ-022.
REQ-029 Macro PHASE_SEQ_STEP_EN undefined:
- step_mode and step SHALL be ignored (ports kept, inputs unused).
- The block SHALL behave as if step_mode=0 permanently.

Verification
REQ-030 NUM_PHASES=4, PHASE_CYCLES=1, run=1 from reset release -> phase_out 0001,0010,0100,1000 repeating; cycle_done every 4th clock; macro_count=3 after 12 clocks.
REQ-031 NUM_PHASES=3, PHASE_CYCLES=2, run=1 -> each bit high exactly 2 clocks; phase_idx 0,0,1,1,2,2; macro-cycle period 6 clocks.
REQ-032 NUM_PHASES=4, run drops during phase 1 -> phases 2 and 3 still complete; then IDLE with phase_out=0 and macro_count incremented once.
REQ-033 With PHASE_SEQ_STEP_EN, step_mode=1: step pulse -> exactly one 4-phase cycle then IDLE; second step during busy ignored; macro_count=1.
REQ-034 reset=0 pulsed asynchronously in phase 2 -> all outputs 0 before the next clock edge; macro_count stays 0.
REQ-035 macro_count preloaded via force to 0xFFFFFFFF, one macro-cycle completes -> macro_count=0 and cycle_done pulses once.

Source files
------------

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer
// Brief    : Generates NUM_PHASES non-overlapping one-hot phase enables, each
//            held for PHASE_CYCLES clocks. Runs continuous macro-cycles while
//            run=1, or exactly one macro-cycle per step pulse in step mode.
//            Optional single-step support is enabled by defining the macro
//            PHASE_SEQ_STEP_EN; without it step_mode/step are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module phase_sequencer #(
    parameter int NUM_PHASES   = 4,
    parameter int PHASE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  step_mode,
    input  logic                  step,
    output logic [NUM_PHASES-1:0] phase_out,
    output logic [2:0]            phase_idx,
    output logic                  busy,
    output logic                  cycle_done,
    output logic [31:0]           macro_count
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0]            c_sub_last   = 4'(PHASE_CYCLES - 1);
    localparam logic [2:0]            c_phase_last = 3'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] c_one        = NUM_PHASES'(1);

    state_t                  state_q, state_d;
    logic [2:0]              phase_q, phase_d;
    logic [3:0]              sub_q, sub_d;
    logic [NUM_PHASES-1:0]   phase_out_q, phase_out_d;
    logic [2:0]              phase_idx_q, phase_idx_d;
    logic                    busy_q, busy_d;
    logic                    cycle_done_q, cycle_done_d;
    logic [31:0]             macro_count_q, macro_count_d;

    logic                    w_step_mode;
    logic                    w_start;
    logic                    w_continue;
    logic                    w_run_d;

`ifdef PHASE_SEQ_STEP_EN
    assign w_step_mode = step_mode;
    assign w_start     = (run & ~step_mode) | (step & step_mode);
`else
    // Step support absent: behave as though step_mode is tied low.
    logic unused_step_inputs;
    assign unused_step_inputs = step_mode | step;
    assign w_step_mode        = 1'b0;
    assign w_start            = run;
`endif

    // Back-to-back macro-cycles only in free-running mode; sampled at boundary.
    assign w_continue = run & ~w_step_mode;

    // Next-state and next-output computation; outputs decoded before the flops.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        sub_d   = sub_q;
        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    state_d = S_RUN;
                    phase_d = 3'd0;
                    sub_d   = 4'd0;
                end
            end
            S_RUN: begin
                if (sub_q == c_sub_last) begin
                    sub_d = 4'd0;
                    if (phase_q == c_phase_last) begin
                        phase_d = 3'd0;
                        if (!w_continue) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        phase_d = phase_q + 3'd1;
                    end
                end else begin
                    sub_d = sub_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = 3'd0;
                sub_d   = 4'd0;
            end
        endcase

        w_run_d       = (state_d == S_RUN);
        phase_out_d   = w_run_d ? (c_one << phase_d) : '0;
        phase_idx_d   = w_run_d ? phase_d : 3'd0;
        busy_d        = w_run_d;
        // Last clock of the macro-cycle: flagged and counted together.
        cycle_done_d  = w_run_d && (phase_d == c_phase_last) && (sub_d == c_sub_last);
        macro_count_d = macro_count_q + {31'd0, cycle_done_d};
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            phase_q       <= 3'd0;
            sub_q         <= 4'd0;
            phase_out_q   <= '0;
            phase_idx_q   <= 3'd0;
            busy_q        <= 1'b0;
            cycle_done_q  <= 1'b0;
            macro_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            sub_q         <= sub_d;
            phase_out_q   <= phase_out_d;
            phase_idx_q   <= phase_idx_d;
            busy_q        <= busy_d;
            cycle_done_q  <= cycle_done_d;
            macro_count_q <= macro_count_d;
        end
    end

    assign phase_out   = phase_out_q;
    assign phase_idx   = phase_idx_q;
    assign busy        = busy_q;
    assign cycle_done  = cycle_done_q;
    assign macro_count = macro_count_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_sequencer
// Brief    : Self-checking bench for phase_sequencer. Two instances
//            (4 phases x 1 clock, 3 phases x 2 clocks) share stimulus and are
//            compared every clock against a position-in-macro-cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

    typedef struct packed {
        bit          active;
        int          t;
        int unsigned cnt;
        bit          done;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, step_mode, step;
    logic [3:0]  phase_out1;
    logic [2:0]  phase_idx1;
    logic        busy1, cycle_done1;
    logic [31:0] macro_count1;
    logic [2:0]  phase_out2;
    logic [2:0]  phase_idx2;
    logic        busy2, cycle_done2;
    logic [31:0] macro_count2;

    int   checks   = 0;
    int   failures = 0;
    mdl_t m1, m2;

    always #5 clk = ~clk;

    phase_sequencer #(.NUM_PHASES(4), .PHASE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run), .step_mode(step_mode), .step(step),
        .phase_out(phase_out1), .phase_idx(phase_idx1), .busy(busy1),
        .cycle_done(cycle_done1), .macro_count(macro_count1)
    );

    phase_sequencer #(.NUM_PHASES(3), .PHASE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run), .step_mode(step_mode), .step(step),
        .phase_out(phase_out2), .phase_idx(phase_idx2), .busy(busy2),
        .cycle_done(cycle_done2), .macro_count(macro_count2)
    );

    // Reference: a macro-cycle is n*p clocks; position t selects phase t/p.
    function automatic mdl_t mdl_next(mdl_t m, int n, int p, bit r, bit sm, bit st);
        mdl_t x;
        bit   sme;
        int   len;
        x   = m;
        len = n * p;
`ifdef PHASE_SEQ_STEP_EN
        sme = sm;
`else
        sme = 1'b0;
`endif
        if (!x.active) begin
            if ((r && !sme) || (st && sme)) begin
                x.active = 1'b1;
                x.t      = 0;
            end
        end else if (x.t == len - 1) begin
            if (r && !sme) x.t = 0;
            else           x.active = 1'b0;
        end else begin
            x.t = x.t + 1;
        end
        x.done = x.active && (x.t == len - 1);
        if (x.done) x.cnt = x.cnt + 1;
        return x;
    endfunction

    function automatic logic [31:0] exp_po(mdl_t m, int p);
        return m.active ? (32'd1 << (m.t / p)) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_idx(mdl_t m, int p);
        return m.active ? 32'(m.t / p) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all();
        chk("po1",   32'(phase_out1),  exp_po(m1, 1));
        chk("idx1",  32'(phase_idx1),  exp_idx(m1, 1));
        chk("busy1", 32'(busy1),       32'(m1.active));
        chk("done1", 32'(cycle_done1), 32'(m1.done));
        chk("cnt1",  macro_count1,     m1.cnt);
        chk("po2",   32'(phase_out2),  exp_po(m2, 2));
        chk("idx2",  32'(phase_idx2),  exp_idx(m2, 2));
        chk("busy2", 32'(busy2),       32'(m2.active));
        chk("done2", 32'(cycle_done2), 32'(m2.done));
        chk("cnt2",  macro_count2,     m2.cnt);
    endtask

    // One clock: model samples the same inputs as the DUTs, check mid-period.
    task automatic tick();
        @(posedge clk);
        m1 = mdl_next(m1, 4, 1, run, step_mode, step);
        m2 = mdl_next(m2, 3, 2, run, step_mode, step);
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset pulse between clock edges, checked before next edge.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        m1 = '0;
        m2 = '0;
        #1 check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; run = 1'b0; step_mode = 1'b0; step = 1'b0;
        m1 = '0; m2 = '0;
        #1 rst_n = 1'b0;
        #1 check_all();

        // Continuous run from reset release.
        @(negedge clk);
        run   = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        chk("cnt1_after_12", macro_count1, 32'd3);
        chk("cnt2_after_12", macro_count2, 32'd2);

        // Drain to idle, then drop run during phase 1: cycle still completes.
        run = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        run = 1'b1;
        tick(); tick();
        run = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("cnt1_run_drop", macro_count1, 32'd4);
        chk("po1_run_drop",  32'(phase_out1), 32'd0);

        // Asynchronous reset while in phase 2.
        run = 1'b1;
        tick(); tick(); tick();
        chk("idx1_before_rst", 32'(phase_idx1), 32'd2);
        run = 1'b0;
        async_reset();
        chk("cnt1_after_rst", macro_count1, 32'd0);
        tick();

        // Counter wrap from all ones.
        force dut1.macro_count_q = 32'hFFFF_FFFF;
        #1 release dut1.macro_count_q;
        m1.cnt = 32'hFFFF_FFFF;
        run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("cnt1_wrap", macro_count1, 32'd0);
        run = 1'b0;
        for (int i = 0; i < 6; i++) tick();

`ifdef PHASE_SEQ_STEP_EN
        // Single step: one cycle only, second step while busy dropped.
        async_reset();
        step_mode = 1'b1; run = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("step_cnt1", macro_count1, 32'd1);
        chk("step_busy1", 32'(busy1), 32'd0);
        step_mode = 1'b0; run = 1'b0;
`endif

        // Randomized operation with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            run       = ($urandom_range(0, 9) < 7);
            step_mode = ($urandom_range(0, 9) < 3);
            step      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) async_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
